// File: rtl/hazard_ctrl.sv
// Load-use stall / branch flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM).
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters; otherwise they read 0.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      IFID_ir_i,
    input  logic             IDEX_mem_read_i,
    input  logic [4:0]       IDEX_rt_i,
    input  logic             MEM_ctrl_pc_src_i,
    output logic             ID_stall_o,
    output logic             IDEX_bubble_o,
    output logic             IFID_flush_o,
    output logic             IDEX_flush_o,
    output logic             EXMEM_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned CNT_LAT_W = 4;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t                 r_state;
    logic [CNT_LAT_W-1:0]   r_cnt;

    logic [5:0] w_opcode;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_uses_rt;
    logic       w_load_use;
    logic       w_flush;
    logic       w_stall;
    logic       w_unused_ir;

    assign w_opcode    = IFID_ir_i[31:26];
    assign w_rs        = IFID_ir_i[25:21];
    assign w_rt        = IFID_ir_i[20:16];
    assign w_unused_ir = ^IFID_ir_i[15:0];

    // Hazard detection against the load sitting in ID/EX
    always_comb begin
        w_uses_rt  = 1'b0;
        w_load_use = 1'b0;
        w_uses_rt  = (w_opcode == OP_RTYPE) || (w_opcode == OP_BEQ) ||
                     (w_opcode == OP_BNE)   || (w_opcode == OP_SW);
        w_load_use = IDEX_mem_read_i && (IDEX_rt_i != 5'd0) &&
                     ((IDEX_rt_i == w_rs) || (w_uses_rt && (IDEX_rt_i == w_rt)));
    end

    // Flush wins over stall; reset forces every control output low without a clock
    always_comb begin
        w_flush = 1'b0;
        w_stall = 1'b0;
        if (!rst_i) begin
            w_flush = MEM_ctrl_pc_src_i;
            w_stall = !MEM_ctrl_pc_src_i && ((r_state == S_STALL) || w_load_use);
        end
    end

    assign ID_stall_o    = w_stall;
    assign IDEX_bubble_o = w_stall;
    assign IFID_flush_o  = w_flush;
    assign IDEX_flush_o  = w_flush;
    assign EXMEM_flush_o = w_flush;

    // The first stall cycle happens in RUN, so STALL covers the remaining LOAD_LAT-1 cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!MEM_ctrl_pc_src_i && w_load_use && (LOAD_LAT > 1)) begin
                        r_state <= S_STALL;
                        r_cnt   <= CNT_LAT_W'(LOAD_LAT - 1);
                    end
                end
                S_STALL: begin
                    if (MEM_ctrl_pc_src_i || (r_cnt == CNT_LAT_W'(1))) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt - CNT_LAT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating event counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (MEM_ctrl_pc_src_i && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (LOAD_LAT 1, 3, 4) share one directed stimulus.
module tb_hazard_ctrl;

    localparam logic [31:0] IR_ADD = 32'h00441820;
    localparam logic [31:0] IR_SW  = 32'hACE20000;

    typedef struct {
        int       row;
        logic [2:0] s;
        logic     fl;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] ir;
    logic        mr;
    logic [4:0]  rt;
    logic        br;

    logic [2:0]  stall;
    logic [2:0]  bub;
    logic [2:0]  f_ifid;
    logic [2:0]  f_idex;
    logic [2:0]  f_exmem;
    logic [31:0] sc [3];
    logic [31:0] fc [3];

    int          n_cmp;
    int          n_err;
    int          row;
    exp_t        q[$];
    logic [31:0] exp_sc [3];
    logic [31:0] exp_fc [3];

    hazard_ctrl #(.LOAD_LAT(1), .CNT_W(32)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .IFID_ir_i(ir), .IDEX_mem_read_i(mr), .IDEX_rt_i(rt),
        .MEM_ctrl_pc_src_i(br), .ID_stall_o(stall[0]), .IDEX_bubble_o(bub[0]),
        .IFID_flush_o(f_ifid[0]), .IDEX_flush_o(f_idex[0]), .EXMEM_flush_o(f_exmem[0]),
        .stall_cnt_o(sc[0]), .flush_cnt_o(fc[0])
    );
    hazard_ctrl #(.LOAD_LAT(3), .CNT_W(32)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .IFID_ir_i(ir), .IDEX_mem_read_i(mr), .IDEX_rt_i(rt),
        .MEM_ctrl_pc_src_i(br), .ID_stall_o(stall[1]), .IDEX_bubble_o(bub[1]),
        .IFID_flush_o(f_ifid[1]), .IDEX_flush_o(f_idex[1]), .EXMEM_flush_o(f_exmem[1]),
        .stall_cnt_o(sc[1]), .flush_cnt_o(fc[1])
    );
    hazard_ctrl #(.LOAD_LAT(4), .CNT_W(32)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .IFID_ir_i(ir), .IDEX_mem_read_i(mr), .IDEX_rt_i(rt),
        .MEM_ctrl_pc_src_i(br), .ID_stall_o(stall[2]), .IDEX_bubble_o(bub[2]),
        .IFID_flush_o(f_ifid[2]), .IDEX_flush_o(f_idex[2]), .EXMEM_flush_o(f_exmem[2]),
        .stall_cnt_o(sc[2]), .flush_cnt_o(fc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs after the edge; s = {lat1, lat3, lat4} expected stall
    task automatic step(input logic [31:0] i_ir, input logic i_mr, input logic [4:0] i_rt,
                        input logic i_br, input logic [2:0] s, input logic fl);
        exp_t e;
        @(posedge clk);
        #1;
        ir = i_ir; mr = i_mr; rt = i_rt; br = i_br;
        e.row = row; e.s = s; e.fl = fl;
        q.push_back(e);
        row++;
    endtask

    // Everything must read 0 while reset is held, regardless of inputs
    task automatic chk_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({stall[k], bub[k], f_ifid[k], f_idex[k], f_exmem[k]} != 5'b0) begin
                n_err++;
                $display("FAIL %s ctl dut%0d: got %b want 00000", tag, k,
                         {stall[k], bub[k], f_ifid[k], f_idex[k], f_exmem[k]});
            end
            n_cmp++;
            if ((sc[k] != 32'd0) || (fc[k] != 32'd0)) begin
                n_err++;
                $display("FAIL %s cnt dut%0d: got stall=%0d flush=%0d want 0/0", tag, k, sc[k], fc[k]);
            end
        end
    endtask

    // Monitor: control outputs are combinational, sampled mid-cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic es;
            e = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                es = e.s[2-k];
                n_cmp++;
                if ({stall[k], bub[k], f_ifid[k], f_idex[k], f_exmem[k]} != {es, es, e.fl, e.fl, e.fl}) begin
                    n_err++;
                    $display("FAIL row%0d ctl dut%0d: got %b want %b", e.row, k,
                             {stall[k], bub[k], f_ifid[k], f_idex[k], f_exmem[k]},
                             {es, es, e.fl, e.fl, e.fl});
                end
                n_cmp++;
                if ((sc[k] != exp_sc[k]) || (fc[k] != exp_fc[k])) begin
                    n_err++;
                    $display("FAIL row%0d cnt dut%0d: got stall=%0d flush=%0d want %0d/%0d",
                             e.row, k, sc[k], fc[k], exp_sc[k], exp_fc[k]);
                end
`ifdef HAZARD_PERF_CNT_EN
                exp_sc[k] = exp_sc[k] + 32'(es);
                exp_fc[k] = exp_fc[k] + 32'(e.fl);
`endif
            end
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; row = 0;
        for (int k = 0; k < 3; k++) begin
            exp_sc[k] = '0;
            exp_fc[k] = '0;
        end
        rst = 1'b1; ir = '0; mr = 1'b0; rt = '0; br = 1'b0;
        #1;
        ir = IR_ADD; mr = 1'b1; rt = 5'd2; br = 1'b1;
        #1;
        chk_zero("por");
        @(negedge clk);
        ir = '0; mr = 1'b0; rt = '0; br = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // load-use on rs
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0);
        step(IR_ADD, 1'b1, 5'd2, 1'b0, 3'b111, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b011, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b011, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b001, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0);
        // sw uses rt
        step(IR_SW,  1'b1, 5'd2, 1'b0, 3'b111, 1'b0);
        step(IR_SW,  1'b0, 5'd0, 1'b0, 3'b011, 1'b0);
        step(IR_SW,  1'b0, 5'd0, 1'b0, 3'b011, 1'b0);
        step(IR_SW,  1'b0, 5'd0, 1'b0, 3'b001, 1'b0);
        // false hazards: $0, no register match, no load, lw does not read rt
        step(32'h00001820, 1'b1, 5'd0, 1'b0, 3'b000, 1'b0);
        step(32'h00A61820, 1'b1, 5'd7, 1'b0, 3'b000, 1'b0);
        step(IR_ADD,       1'b0, 5'd2, 1'b0, 3'b000, 1'b0);
        step(32'h8CA60000, 1'b1, 5'd6, 1'b0, 3'b000, 1'b0);
        // branch beats a same-cycle load-use
        step(IR_ADD, 1'b1, 5'd2, 1'b1, 3'b000, 1'b1);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0);
        // branch in the second stall cycle aborts the stall
        step(IR_ADD, 1'b1, 5'd2, 1'b0, 3'b111, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b1, 3'b000, 1'b1);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0);
        // load-use held during STALL is ignored by the multi-cycle instances
        step(IR_ADD, 1'b1, 5'd2, 1'b0, 3'b111, 1'b0);
        step(IR_ADD, 1'b1, 5'd2, 1'b0, 3'b111, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b011, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b001, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0);
        // R-type match on rt field
        step(IR_ADD, 1'b1, 5'd4, 1'b0, 3'b111, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b011, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b011, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b001, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0);
        // enter STALL, then reset between edges
        step(IR_ADD, 1'b1, 5'd2, 1'b0, 3'b111, 1'b0);

        @(posedge clk);
        #1;
        ir = IR_ADD; mr = 1'b1; rt = 5'd2; br = 1'b1;
        #2;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_sc[k] = '0;
            exp_fc[k] = '0;
        end
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        ir = IR_ADD; mr = 1'b0; rt = '0; br = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0);
        step(IR_ADD, 1'b1, 5'd2, 1'b0, 3'b111, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b011, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b011, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b001, 1'b0);
        step(IR_ADD, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0);

        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
